// File: rtl/pid_alloc_pkg.sv
// rtl/pid_alloc_pkg.sv - shared constants and types for the PID free-list controller
// Contents: slot counts, reserved ranges, encoder grouping, pid_t, reset_bitmap()
package pid_alloc_pkg;

   localparam int NUM_PID    = 512;
   localparam int PID_WIDTH  = 9;
   localparam int RESV_LO    = 8;
   localparam int RESV_HI    = 8;

   localparam int PID_FIRST  = RESV_LO;
   localparam int PID_LAST   = NUM_PID - RESV_HI - 1;
   localparam int PID_USABLE = PID_LAST - PID_FIRST + 1;

   // Two-level priority encode: NUM_GRP groups of GRP_SIZE bits.
   localparam int GRP_SIZE   = 32;
   localparam int GRP_BITS   = 5;
   localparam int NUM_GRP    = NUM_PID / GRP_SIZE;
   localparam int SEL_BITS   = PID_WIDTH - GRP_BITS;

   typedef logic [PID_WIDTH-1:0] pid_t;

   // Bitmap after reset: only the allocatable range is free.
   function automatic logic [NUM_PID-1:0] reset_bitmap();
      logic [NUM_PID-1:0] m;
      for (int i = 0; i < NUM_PID; i++) begin
         m[i] = (i >= PID_FIRST) && (i <= PID_LAST);
      end
      return m;
   endfunction

endpackage

// File: rtl/pid_prio_enc.sv
// rtl/pid_prio_enc.sv - two-level lowest-set-bit encoder over the PID bitmap
// Ports: vec (in, NUM_PID) bitmap; idx (out, PID_WIDTH) lowest set index; found (out) any bit set
module pid_prio_enc
   import pid_alloc_pkg::*;
(
   input  logic [NUM_PID-1:0] vec,
   output pid_t               idx,
   output logic               found
);

   logic [NUM_GRP-1:0]               grp_any;
   logic [NUM_GRP-1:0][GRP_BITS-1:0] grp_idx;

   // First level: per-group OR and lowest index inside the group.
   // Scanning high to low leaves the lowest set bit as the final value.
   always_comb begin
      grp_any = '0;
      grp_idx = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         grp_any[g] = |vec[g*GRP_SIZE +: GRP_SIZE];
         for (int b = GRP_SIZE - 1; b >= 0; b--) begin
            if (vec[g*GRP_SIZE + b]) begin
               grp_idx[g] = GRP_BITS'(b);
            end
         end
      end
   end

   // Second level: lowest non-empty group selects its local index.
   always_comb begin
      idx   = '0;
      found = |grp_any;
      for (int g = NUM_GRP - 1; g >= 0; g--) begin
         if (grp_any[g]) begin
            idx = {SEL_BITS'(g), grp_idx[g]};
         end
      end
   end

endmodule

// File: rtl/pid_alloc.sv
// rtl/pid_alloc.sv - PID free-list controller with one prefetched free PID
// Ports: clk, reset (sync, active-high); alloc_valid/alloc_pid (out) prefetched PID;
//        alloc_rd (in) consume it; rel_valid/rel_pid (in) PID return;
//        free_cnt (out) free PIDs incl. held one; empty (out);
//        err_double_free, err_underflow (out) one-cycle error pulses
module pid_alloc
   import pid_alloc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic        alloc_valid,
   output logic [8:0]  alloc_pid,
   input  logic        alloc_rd,
   input  logic        rel_valid,
   input  logic [8:0]  rel_pid,
   output logic [9:0]  free_cnt,
   output logic        empty,
   output logic        err_double_free,
   output logic        err_underflow
);

   logic [NUM_PID-1:0] bitmap;
   logic [NUM_PID-1:0] bitmap_nxt;
   pid_t               enc_idx;
   logic               enc_found;

   logic               load;
   logic               rd_ok;
   logic               rel_in_range;
   logic               rel_ok;
   logic               rel_bad;
   logic [9:0]         free_cnt_nxt;

   // Search runs on the registered bitmap, so a release is visible one cycle later.
   pid_prio_enc u_enc (
      .vec   (bitmap),
      .idx   (enc_idx),
      .found (enc_found)
   );

   always_comb begin
      load         = !alloc_valid || alloc_rd;
      rd_ok        = alloc_rd && alloc_valid;
      rel_in_range = (rel_pid >= PID_WIDTH'(PID_FIRST)) && (rel_pid <= PID_WIDTH'(PID_LAST));
      // A held PID counts as free, so returning it is a duplicate even if it is
      // being consumed this very cycle.
      rel_ok       = rel_valid && rel_in_range && !bitmap[rel_pid]
                     && !(alloc_valid && (rel_pid == alloc_pid));
      rel_bad      = rel_valid && !rel_ok;

      // The prefetched bit is set and the released bit is clear, so these never collide.
      bitmap_nxt = bitmap;
      if (load && enc_found) begin
         bitmap_nxt[enc_idx] = 1'b0;
      end
      if (rel_ok) begin
         bitmap_nxt[rel_pid] = 1'b1;
      end

      case ({rel_ok, rd_ok})
         2'b10:   free_cnt_nxt = free_cnt + 10'd1;
         2'b01:   free_cnt_nxt = free_cnt - 10'd1;
         default: free_cnt_nxt = free_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bitmap          <= reset_bitmap();
         alloc_valid     <= 1'b0;
         alloc_pid       <= '0;
         free_cnt        <= 10'(PID_USABLE);
         err_double_free <= 1'b0;
         err_underflow   <= 1'b0;
      end else begin
         bitmap          <= bitmap_nxt;
         free_cnt        <= free_cnt_nxt;
         err_double_free <= rel_bad;
         err_underflow   <= alloc_rd && !alloc_valid;
         if (load) begin
            alloc_valid <= enc_found;
            if (enc_found) begin
               alloc_pid <= enc_idx;
            end
         end
      end
   end

   assign empty = (free_cnt == 10'd0);

endmodule
